// File: rtl/level_pkg.sv
// level_pkg: state encoding and default widths shared by the level sequencer
package level_pkg;

    typedef enum logic [2:0] {IDLE, SPAWN, PLAY, PAUSE, WON} state_t;

    localparam int N_ENEMIES_DEF    = 5;
    localparam int LEVEL_W_DEF      = 4;
    localparam int MAX_LEVEL_DEF    = 9;
    localparam int PAUSE_CYCLES_DEF = 100000;
    localparam int CNT_W_DEF        = 17;

endpackage

// File: rtl/level_pause_timer.sv
// level_pause_timer: inter-level pause counter, counts 0..PAUSE_CYCLES-1 while enabled
// Ports: pclk/rst clock and sync reset; clr zeroes the count; en advances it;
//        done is high on the last enabled count.
module level_pause_timer
    import level_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int PAUSE_CYCLES = PAUSE_CYCLES_DEF
) (
    input  logic pclk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [CNT_W-1:0] cnt;

    assign done = en && cnt == CNT_W'(PAUSE_CYCLES - 1);

    always_ff @(posedge pclk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= done ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/level_ctrl.sv
// level_ctrl: level sequencer that advances on cleared waves, pauses, then requests a new wave
// Ports: pclk/rst clock and sync active-high reset; start begins a game from IDLE;
//        restart returns to level 1; alive per-enemy flags; spawn_ack accepts spawn_req;
//        level/level_up/playing/game_won feed the HUD. Optional LEVEL_SKIP_EN macro adds
//        a skip input that clears the current wave immediately.
module level_ctrl
    import level_pkg::*;
#(
    parameter int N_ENEMIES    = N_ENEMIES_DEF,
    parameter int LEVEL_W      = LEVEL_W_DEF,
    parameter int MAX_LEVEL    = MAX_LEVEL_DEF,
    parameter int PAUSE_CYCLES = PAUSE_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 restart,
    input  logic [N_ENEMIES-1:0] alive,
    input  logic                 spawn_ack,
`ifdef LEVEL_SKIP_EN
    input  logic                 skip,
`endif
    output logic [LEVEL_W-1:0]   level,
    output logic                 level_up,
    output logic                 spawn_req,
    output logic                 playing,
    output logic                 game_won
);

    state_t state;
    logic   zero_seen;
    logic   all_zero;
    logic   wave_clear;
    logic   hit_max;
    logic   pause_done;

    assign all_zero = alive == '0;
    assign hit_max  = level == LEVEL_W'(MAX_LEVEL);

    // Two consecutive all-zero samples filter out glitches while the spawner loads.
`ifdef LEVEL_SKIP_EN
    assign wave_clear = (all_zero && zero_seen) || skip;
`else
    assign wave_clear = all_zero && zero_seen;
`endif

    // Held in clear outside PAUSE, so every PAUSE entry starts from zero.
    level_pause_timer #(
        .CNT_W       (CNT_W),
        .PAUSE_CYCLES(PAUSE_CYCLES)
    ) u_timer (
        .pclk(pclk),
        .rst (rst),
        .clr (state != PAUSE),
        .en  (state == PAUSE),
        .done(pause_done)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            level     <= LEVEL_W'(1);
            level_up  <= 1'b0;
            spawn_req <= 1'b0;
            playing   <= 1'b0;
            game_won  <= 1'b0;
            zero_seen <= 1'b0;
        end else begin
            level_up <= 1'b0;
            if (state != IDLE && restart) begin
                state     <= SPAWN;
                level     <= LEVEL_W'(1);
                spawn_req <= 1'b1;
                playing   <= 1'b0;
                game_won  <= 1'b0;
                zero_seen <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state     <= SPAWN;
                        spawn_req <= 1'b1;
                    end
                    SPAWN: if (spawn_ack) begin
                        state     <= PLAY;
                        spawn_req <= 1'b0;
                        playing   <= 1'b1;
                        zero_seen <= 1'b0;
                    end
                    PLAY: begin
                        zero_seen <= all_zero;
                        if (wave_clear) begin
                            playing <= 1'b0;
                            if (hit_max) begin
                                state    <= WON;
                                game_won <= 1'b1;
                            end else begin
                                state    <= PAUSE;
                                level    <= level + LEVEL_W'(1);
                                level_up <= 1'b1;
                            end
                        end
                    end
                    PAUSE: if (pause_done) begin
                        state     <= SPAWN;
                        spawn_req <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_level_ctrl.sv
// tb_level_ctrl: table, directed and randomized checks of level_ctrl against a reference model
module tb_level_ctrl;

    localparam int MAXL  = 3;
    localparam int PAUSE = 8;
    localparam int M_IDLE = 0, M_SPAWN = 1, M_PLAY = 2, M_PAUSE = 3, M_WON = 4;

    logic       pclk = 1'b0;
    logic       rst = 1'b1, start = 1'b0, restart = 1'b0, spawn_ack = 1'b0, skip = 1'b0;
    logic [4:0] alive = 5'h1f;
    logic [3:0] level;
    logic       level_up, spawn_req, playing, game_won;

    always #5 pclk = ~pclk;

    level_ctrl #(
        .N_ENEMIES(5), .LEVEL_W(4), .MAX_LEVEL(MAXL), .PAUSE_CYCLES(PAUSE), .CNT_W(4)
    ) dut (
        .pclk(pclk), .rst(rst), .start(start), .restart(restart),
        .alive(alive), .spawn_ack(spawn_ack),
`ifdef LEVEL_SKIP_EN
        .skip(skip),
`endif
        .level(level), .level_up(level_up), .spawn_req(spawn_req),
        .playing(playing), .game_won(game_won)
    );

    int vecs = 0;
    int bad  = 0;

    // Reference model: game phase, consecutive-zero run length, pause cycles remaining.
    int m_mode = M_IDLE, m_level = 1, m_zrun = 0, m_pleft = 0;
    bit m_lu = 1'b0;

    task automatic model_step();
        m_lu = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_level = 1;
        end else if (m_mode == M_IDLE) begin
            if (start) m_mode = M_SPAWN;
        end else if (restart) begin
            m_mode = M_SPAWN; m_level = 1;
        end else if (m_mode == M_SPAWN) begin
            if (spawn_ack) begin m_mode = M_PLAY; m_zrun = 0; end
        end else if (m_mode == M_PLAY) begin
            m_zrun = (alive == 0) ? m_zrun + 1 : 0;
            if (m_zrun >= 2 || skip) begin
                if (m_level == MAXL) m_mode = M_WON;
                else begin
                    m_level = m_level + 1; m_lu = 1'b1; m_mode = M_PAUSE; m_pleft = PAUSE;
                end
            end
        end else if (m_mode == M_PAUSE) begin
            m_pleft = m_pleft - 1;
            if (m_pleft == 0) m_mode = M_SPAWN;
        end
    endtask

    function automatic logic [7:0] model_exp();
        return {4'(m_level), m_lu, m_mode == M_SPAWN, m_mode == M_PLAY, m_mode == M_WON};
    endfunction

    task automatic check(string nm, logic [7:0] exp);
        logic [7:0] act;
        act = {level, level_up, spawn_req, playing, game_won};
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got lvl=%0d lu=%b req=%b play=%b won=%b, expected lvl=%0d lu=%b req=%b play=%b won=%b",
                     nm, act[7:4], act[3], act[2], act[1], act[0], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic cyc(string nm, bit r, bit st, bit rs, logic [4:0] al, bit ak, bit sk,
                       bit use_model, logic [7:0] texp);
        rst = r; start = st; restart = rs; alive = al; spawn_ack = ak; skip = sk;
        @(posedge pclk);
        model_step();
        @(negedge pclk);
        check(nm, use_model ? model_exp() : texp);
    endtask

    task automatic m(string nm, bit st, bit rs, logic [4:0] al, bit ak, bit sk);
        cyc(nm, 1'b0, st, rs, al, ak, sk, 1'b1, 8'h0);
    endtask

    typedef struct {
        bit st, rs, ak;
        logic [4:0] al;
        logic [3:0] lv;
        bit lu, rq, pl, wn;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit st, bit rs, bit ak, logic [4:0] al,
                                logic [3:0] lv, bit lu, bit rq, bit pl, bit wn);
        vec_t t;
        t.st = st; t.rs = rs; t.ak = ak; t.al = al;
        t.lv = lv; t.lu = lu; t.rq = rq; t.pl = pl; t.wn = wn;
        return t;
    endfunction

    initial begin
        tbl.push_back(mk(1, 0, 0, 5'h1f, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5'h1f, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5'h00, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 5'h1f, 1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 5'h1f, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 5'h00, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 5'h00, 2, 1, 0, 0, 0));
        for (int i = 0; i < PAUSE - 1; i++)
            tbl.push_back(mk(0, 0, i == 1, 5'h00, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 5'h00, 2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 5'h00, 2, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 5'h00, 2, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 5'h01, 2, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 5'h00, 2, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 5'h00, 3, 1, 0, 0, 0));

        cyc("reset0", 1, 0, 0, 5'h1f, 0, 0, 0, 8'b0001_0000);
        cyc("reset1", 1, 1, 1, 5'h00, 1, 0, 0, 8'b0001_0000);
        for (int i = 0; i < tbl.size(); i++)
            cyc($sformatf("tbl[%0d]", i), 0, tbl[i].st, tbl[i].rs, tbl[i].al, tbl[i].ak, 0, 0,
                {tbl[i].lv, tbl[i].lu, tbl[i].rq, tbl[i].pl, tbl[i].wn});

        for (int i = 0; i < PAUSE; i++) m("pause_l3", 0, 0, 5'h1f, 0, 0);
        m("ack_l3", 0, 0, 5'h1f, 1, 0);
        m("zero1_l3", 0, 0, 5'h00, 0, 0);
        m("clear_max", 0, 0, 5'h00, 0, 0);
        for (int i = 0; i < 4; i++) m("won_hold", 1, 0, 5'h00, 1, 0);

        m("restart_won", 0, 1, 5'h1f, 0, 0);
        m("ack_a", 0, 0, 5'h1f, 1, 0);
        m("zero1_a", 0, 0, 5'h00, 0, 0);
        m("clear_a", 0, 0, 5'h00, 0, 0);
        for (int i = 0; i < 3; i++) m("pause_a", 0, 0, 5'h00, 0, 0);
        m("restart_pause", 0, 1, 5'h00, 0, 0);
        m("ack_b", 0, 0, 5'h1f, 1, 0);
        m("zero1_b", 0, 0, 5'h00, 0, 0);
        m("clear_b", 0, 0, 5'h00, 0, 0);
        for (int i = 0; i < PAUSE + 1; i++) m("pause_full", 0, 0, 5'h00, 0, 0);
        m("ack_c", 0, 0, 5'h1f, 1, 0);
        m("zero1_c", 0, 0, 5'h00, 0, 0);
        m("restart_vs_clear", 0, 1, 5'h00, 0, 0);

        cyc("reset2", 1, 0, 0, 5'h1f, 0, 0, 1, 8'h0);
        m("start_restart_idle", 1, 1, 5'h1f, 0, 0);
`ifdef LEVEL_SKIP_EN
        m("ack_s", 0, 0, 5'h15, 1, 0);
        m("play_s", 0, 0, 5'h15, 0, 0);
        m("skip", 0, 0, 5'h15, 0, 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            bit r, st, rs, ak, sk;
            logic [4:0] al;
            r  = $urandom_range(0, 299) == 0;
            st = $urandom_range(0, 15) == 0;
            rs = $urandom_range(0, 79) == 0;
            ak = $urandom_range(0, 3) == 0;
            al = ($urandom_range(0, 2) != 0) ? 5'h00 : 5'($urandom);
`ifdef LEVEL_SKIP_EN
            sk = $urandom_range(0, 19) == 0;
`else
            sk = 1'b0;
`endif
            cyc("random", r, st, rs, al, ak, sk, 1, 8'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
